// File: rtl/fifo_ptr_pkg.sv
// Shared constants and Gray/binary helpers for the async FIFO pointer engines.
// Helpers operate at PTR_MAX_W bits; callers zero-extend and truncate with casts.
package fifo_ptr_pkg;

    localparam int PTR_MODE_WR = 0;
    localparam int PTR_MODE_RD = 1;
    localparam int PTR_MAX_W   = 32;

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
        logic [PTR_MAX_W-1:0] bin;
        bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_gray_ptr_gray_sync.sv
// Reset-clearable flop chain carrying the remote Gray pointer into clk; STAGES cycles latency.
// No backpressure: samples d every cycle. Isolated so CDC constraints target this module only.
module gray_sync
    import fifo_ptr_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/fifo_gray_ptr.sv
// Pointer engine for one side of the async FIFO: binary/Gray pointer, synced remote pointer, full/empty flag.
// Flag is registered; inc_i is ignored while the flag is set. Optional level_o under FIFO_PTR_LEVEL_EN.
module fifo_gray_ptr
    import fifo_ptr_pkg::*;
#(
    parameter  int DEPTH       = 32,
    parameter  int SYNC_STAGES = 2,
    parameter  int MODE        = PTR_MODE_WR,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc_i,
    input  logic [AW:0]   rgray_i,
    output logic [AW:0]   ptr_o,
    output logic [AW-1:0] addr_o,
    output logic [AW:0]   gray_o,
    output logic          flag_o
`ifdef FIFO_PTR_LEVEL_EN
    ,
    output logic [AW:0]   level_o
`endif
);

    // Full means the remote pointer is one lap behind: top two Gray bits inverted.
    localparam logic [AW:0] FULL_MASK = (AW+1)'(3) << (AW - 1);

    logic [AW:0] rsync;
    logic [AW:0] bin_nxt;
    logic [AW:0] gray_nxt;
    logic        accept;
    logic        flag_nxt;

    gray_sync #(
        .WIDTH  (AW + 1),
        .STAGES (SYNC_STAGES)
    ) u_gray_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rgray_i),
        .q     (rsync)
    );

    always_comb begin
        accept   = inc_i & ~flag_o;
        bin_nxt  = ptr_o + (AW+1)'(accept);
        gray_nxt = (AW+1)'(bin2gray(PTR_MAX_W'(bin_nxt)));
        if (MODE == PTR_MODE_WR) begin
            flag_nxt = (gray_nxt == (rsync ^ FULL_MASK));
        end else begin
            flag_nxt = (gray_nxt == rsync);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_o  <= '0;
            gray_o <= '0;
            flag_o <= (MODE == PTR_MODE_RD);
        end else begin
            ptr_o  <= bin_nxt;
            gray_o <= gray_nxt;
            flag_o <= flag_nxt;
        end
    end

    assign addr_o = ptr_o[AW-1:0];

`ifdef FIFO_PTR_LEVEL_EN
    logic [AW:0] rbin;

    assign rbin = (AW+1)'(gray2bin(PTR_MAX_W'(rsync)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_o <= '0;
        end else if (MODE == PTR_MODE_WR) begin
            level_o <= bin_nxt - rbin;
        end else begin
            level_o <= rbin - bin_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_gray_ptr.sv
// Directed bench for fifo_gray_ptr (DEPTH=8, SYNC_STAGES=2) with a write-side and a read-side instance.
// Table vectors cover fill/full/drain and empty release; sequences cover wrap, async reset and level.
module tb_fifo_gray_ptr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       inc_w, inc_r;
    logic [3:0] rg_w, rg_r;
    logic [3:0] ptr_w, gray_w, ptr_r, gray_r;
    logic [2:0] addr_w, addr_r;
    logic       flag_w, flag_r;
`ifdef FIFO_PTR_LEVEL_EN
    logic [3:0] level_w, level_r;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fifo_gray_ptr #(.DEPTH(8), .SYNC_STAGES(2), .MODE(0)) u_wr (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (inc_w),
        .rgray_i (rg_w),
        .ptr_o   (ptr_w),
        .addr_o  (addr_w),
        .gray_o  (gray_w),
        .flag_o  (flag_w)
`ifdef FIFO_PTR_LEVEL_EN
        ,
        .level_o (level_w)
`endif
    );

    fifo_gray_ptr #(.DEPTH(8), .SYNC_STAGES(2), .MODE(1)) u_rd (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (inc_r),
        .rgray_i (rg_r),
        .ptr_o   (ptr_r),
        .addr_o  (addr_r),
        .gray_o  (gray_r),
        .flag_o  (flag_r)
`ifdef FIFO_PTR_LEVEL_EN
        ,
        .level_o (level_r)
`endif
    );

    typedef struct {
        logic       side;   // 0 = write instance, 1 = read instance
        logic       inc;
        logic [3:0] rg;
        logic [3:0] ptr;
        logic [3:0] gray;
        logic       flag;
    } vec_t;

    vec_t       tv [20];
    logic [3:0] gtab [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every Gray pointer change seen outside reset must flip exactly one bit.
    logic [3:0] prev_gw, prev_gr;
    logic       prev_ok = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ok = 1'b0;
        end else begin
            if (prev_ok && gray_w !== prev_gw) chk("gray_w_onebit", $countones(gray_w ^ prev_gw), 1);
            if (prev_ok && gray_r !== prev_gr) chk("gray_r_onebit", $countones(gray_r ^ prev_gr), 1);
            prev_gw = gray_w;
            prev_gr = gray_r;
            prev_ok = 1'b1;
        end
    end

    initial begin
        gtab[0]  = 4'b0000; gtab[1]  = 4'b0001; gtab[2]  = 4'b0011; gtab[3]  = 4'b0010;
        gtab[4]  = 4'b0110; gtab[5]  = 4'b0111; gtab[6]  = 4'b0101; gtab[7]  = 4'b0100;
        gtab[8]  = 4'b1100; gtab[9]  = 4'b1101; gtab[10] = 4'b1111; gtab[11] = 4'b1110;
        gtab[12] = 4'b1010; gtab[13] = 4'b1011; gtab[14] = 4'b1001; gtab[15] = 4'b1000;

        // Fill the write side with the read pointer parked at 0.
        tv[0]  = '{1'b0, 1'b1, 4'b0000, 4'd1, 4'b0001, 1'b0};
        tv[1]  = '{1'b0, 1'b1, 4'b0000, 4'd2, 4'b0011, 1'b0};
        tv[2]  = '{1'b0, 1'b1, 4'b0000, 4'd3, 4'b0010, 1'b0};
        tv[3]  = '{1'b0, 1'b1, 4'b0000, 4'd4, 4'b0110, 1'b0};
        tv[4]  = '{1'b0, 1'b1, 4'b0000, 4'd5, 4'b0111, 1'b0};
        tv[5]  = '{1'b0, 1'b1, 4'b0000, 4'd6, 4'b0101, 1'b0};
        tv[6]  = '{1'b0, 1'b1, 4'b0000, 4'd7, 4'b0100, 1'b0};
        tv[7]  = '{1'b0, 1'b1, 4'b0000, 4'd8, 4'b1100, 1'b1};
        tv[8]  = '{1'b0, 1'b1, 4'b0000, 4'd8, 4'b1100, 1'b1};
        // One entry read: full clears on the second edge after the change.
        tv[9]  = '{1'b0, 1'b0, 4'b0001, 4'd8, 4'b1100, 1'b1};
        tv[10] = '{1'b0, 1'b0, 4'b0001, 4'd8, 4'b1100, 1'b1};
        tv[11] = '{1'b0, 1'b0, 4'b0001, 4'd8, 4'b1100, 1'b0};
        tv[12] = '{1'b0, 1'b1, 4'b0001, 4'd9, 4'b1101, 1'b1};
        tv[13] = '{1'b0, 1'b1, 4'b0001, 4'd9, 4'b1101, 1'b1};
        // Read side: remote write pointer moves to 2, pop twice, third pop ignored.
        tv[14] = '{1'b1, 1'b1, 4'b0011, 4'd0, 4'b0000, 1'b1};
        tv[15] = '{1'b1, 1'b0, 4'b0011, 4'd0, 4'b0000, 1'b1};
        tv[16] = '{1'b1, 1'b0, 4'b0011, 4'd0, 4'b0000, 1'b0};
        tv[17] = '{1'b1, 1'b1, 4'b0011, 4'd1, 4'b0001, 1'b0};
        tv[18] = '{1'b1, 1'b1, 4'b0011, 4'd2, 4'b0011, 1'b1};
        tv[19] = '{1'b1, 1'b1, 4'b0011, 4'd2, 4'b0011, 1'b1};

        rst_n = 1'b0;
        inc_w = 1'b0; inc_r = 1'b0;
        rg_w  = 4'b0; rg_r  = 4'b0;
        repeat (2) step();
        chk("rst_ptr_w",  ptr_w,  0);
        chk("rst_gray_w", gray_w, 0);
        chk("rst_flag_w", flag_w, 0);
        chk("rst_ptr_r",  ptr_r,  0);
        chk("rst_flag_r", flag_r, 1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            if (tv[i].side == 1'b0) begin
                inc_w = tv[i].inc; rg_w = tv[i].rg; inc_r = 1'b0;
            end else begin
                inc_r = tv[i].inc; rg_r = tv[i].rg; inc_w = 1'b0;
            end
            step();
            if (tv[i].side == 1'b0) begin
                chk($sformatf("v%0d_ptr_w", i),  ptr_w,  tv[i].ptr);
                chk($sformatf("v%0d_addr_w", i), addr_w, tv[i].ptr[2:0]);
                chk($sformatf("v%0d_gray_w", i), gray_w, tv[i].gray);
                chk($sformatf("v%0d_flag_w", i), flag_w, tv[i].flag);
            end else begin
                chk($sformatf("v%0d_ptr_r", i),  ptr_r,  tv[i].ptr);
                chk($sformatf("v%0d_gray_r", i), gray_r, tv[i].gray);
                chk($sformatf("v%0d_flag_r", i), flag_r, tv[i].flag);
            end
        end
        inc_w = 1'b0; inc_r = 1'b0;

        // Wrap: read side pops 16 times from ptr 2, remote pointer one step ahead each time.
        for (int k = 0; k < 16; k++) begin
            int nxt;
            nxt  = (2 + k + 1) % 16;
            rg_r = gtab[nxt];
            step();
            step();
            chk("wrap_flag_hold", flag_r, 1);
            step();
            chk("wrap_flag_clr", flag_r, 0);
            inc_r = 1'b1;
            step();
            inc_r = 1'b0;
            chk($sformatf("wrap%0d_ptr", k),  ptr_r,  nxt);
            chk($sformatf("wrap%0d_gray", k), gray_r, gtab[nxt]);
            chk($sformatf("wrap%0d_flag", k), flag_r, 1);
        end

        // Asynchronous reset in the middle of a cycle at write ptr 5.
        rst_n = 1'b0; rg_w = 4'b0; rg_r = 4'b0;
        step();
        @(negedge clk);
        rst_n = 1'b1;
        inc_w = 1'b1;
        repeat (5) step();
        inc_w = 1'b0;
        chk("pre_rst_ptr_w", ptr_w, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ptr_w",  ptr_w,  0);
        chk("arst_addr_w", addr_w, 0);
        chk("arst_gray_w", gray_w, 0);
        chk("arst_flag_w", flag_w, 0);
        chk("arst_flag_r", flag_r, 1);
        chk("arst_ptr_r",  ptr_r,  0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        inc_w = 1'b1;
        step();
        inc_w = 1'b0;
        chk("post_rst_ptr_w",  ptr_w,  1);
        chk("post_rst_gray_w", gray_w, 4'b0001);

`ifdef FIFO_PTR_LEVEL_EN
        inc_w = 1'b1;
        repeat (4) step();
        inc_w = 1'b0;
        chk("level_5", level_w, 5);
        chk("level_rd_0", level_r, 0);
        rg_w = 4'b0011;
        step();
        step();
        chk("level_hold", level_w, 5);
        step();
        chk("level_3", level_w, 3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_gray_ptr.md
# fifo_gray_ptr

Parametrised single-domain pointer engine for the UART async FIFO. It holds the local binary and Gray pointers and synchronises the remote Gray pointer through a configurable flop chain. It also generates the registered full flag (write side) or empty flag (read side). One instance sits in each clock domain of the FIFO.

## Interface

Parameters:
- DEPTH, 32: FIFO depth. Power of two, at least 2. AW = $clog2(DEPTH).
- SYNC_STAGES, 2: number of remote-pointer synchroniser flops. At least 2.
- MODE, 0: 0 = write side (flag_o means full), 1 = read side (flag_o means empty).

Ports:
- clk  in  1  local domain clock.
- rst_n  in  1  reset, asynchronous, active-low. Clears every flop in the block.
- inc_i  in  1  push request (write side) or pop request (read side).
- rgray_i  in  AW+1  remote Gray pointer. Asynchronous to clk.
- ptr_o  out  AW+1  registered local binary pointer, including the wrap bit.
- addr_o  out  AW  ptr_o[AW-1:0], the RAM address.
- gray_o  out  AW+1  registered Gray encoding of ptr_o, sent to the remote domain.
- flag_o  out  1  full (MODE 0) or empty (MODE 1). Registered.
- level_o  out  AW+1  occupancy. Present only when FIFO_PTR_LEVEL_EN is defined.

## Operation

- Accept rule: accept = inc_i & ~flag_o. An inc_i while the flag is set is ignored, so no pointer movement, overflow or underflow is possible.
- Next pointer: bin_nxt = ptr_o + accept, computed modulo 2^(AW+1).
- Next Gray value: gray_nxt = bin_nxt ^ (bin_nxt >> 1).
- ptr_o and gray_o register bin_nxt and gray_nxt on the same edge, so they always encode the same value.
- Synchroniser: rgray_i is shifted through SYNC_STAGES flops. The last stage is rsync.
- Full flag (MODE 0): full_r <= (gray_nxt == {~rsync[AW:AW-1], rsync[AW-2:0]}). When AW = 1 both bits are inverted.
- Empty flag (MODE 1): empty_r <= (gray_nxt == rsync).
- Wrap-around: after ptr_o = 2·DEPTH-1, the next accept gives 0. gray_o goes from {1'b1, {AW{1'b0}}} to 0, a single-bit change.
- Simultaneous local accept and remote pointer change: the flag is computed from both new values in the same cycle. No priority is applied.
- Reset values:
  - ptr_o, addr_o, gray_o, rsync chain and level_o are all 0.
  - flag_o is 0 in MODE 0 and 1 in MODE 1.
- Reset asserted mid-operation clears state immediately, asynchronously. The system resets both FIFO sides together; this block does not detect a one-sided reset.

## Timing

- Accept on edge n: ptr_o, gray_o and flag_o reflect it after edge n.
- A flag asserted after edge n blocks any inc_i sampled at edge n+1.
- Remote pointer change stable before edge t: it is visible in rsync after edge t+SYNC_STAGES-1 and in flag_o after edge t+SYNC_STAGES.
- The flags are pessimistic. A full or empty that has actually cleared may persist for up to SYNC_STAGES+1 cycles. A flag is never late in asserting.
- gray_o is driven straight from a flop, with no logic between the register and the remote synchroniser.

## Configuration

- FIFO_PTR_LEVEL_EN defined:
  - level_o port exists.
  - MODE 0: level_o <= bin_nxt - g2b(rsync).
  - MODE 1: level_o <= g2b(rsync) - bin_nxt.
  - Subtraction is AW+1 bits wide, modulo 2^(AW+1), giving a range of 0..DEPTH. Same latency as flag_o.
- FIFO_PTR_LEVEL_EN undefined: no level_o port and no Gray-to-binary logic. Flag behaviour is identical.

## Structure

- Package fifo_ptr_pkg holds:
  - MODE constants PTR_MODE_WR = 0 and PTR_MODE_RD = 1.
  - The bin2gray and gray2bin functions, parametrised by width through a package-level maximum width constant.
- Sub-module gray_sync holds the SYNC_STAGES-deep reset-clearable flop chain, parameterised by WIDTH and STAGES. It is kept separate so the synchroniser constraint and CDC waiver apply to one module.
- The remaining logic (pointer, flag, level) stays in fifo_gray_ptr.

## Test plan

All scenarios use DEPTH=8, SYNC_STAGES=2.
- Fill (MODE 0, rgray_i=0): 8 consecutive inc_i give ptr_o=8, gray_o=4'b1100 and flag_o=1 after the 8th accept. A 9th inc_i leaves ptr_o at 8.
- Drain release (MODE 0, full, ptr_o=8): set rgray_i=4'b0001, i.e. one entry read. flag_o falls exactly 2 cycles after the input change, sampled at the next edges.
- Empty release (MODE 1, after reset flag_o=1): set rgray_i=4'b0011 (binary 2). flag_o=0 after 2 edges. Two accepts give ptr_o=2 and flag_o=1 again. A third inc_i is ignored.
- Wrap: 16 accepts in MODE 1, with rgray_i kept one step ahead. ptr_o goes 15→0 and gray_o 4'b1000→4'b0000. Every gray_o transition across the run changes exactly one bit (checked by assertion).
- Reset mid-run: pulse rst_n low at ptr_o=5. All outputs go to their reset values asynchronously. After release, a single accept gives ptr_o=1.
- Level (FIFO_PTR_LEVEL_EN, MODE 0): 5 accepts with rgray_i=0 give level_o=5. Then rgray_i=4'b0011 gives level_o=3 two cycles later.
